// File: rtl/pattern_seq_ctrl.sv
// rtl/pattern_seq_ctrl.sv - serial pattern match sequencer with config handshake, overlap and match limit
// Optional: define PATTERN_MASK_EN to add cfg_mask (mask=1 bits are don't-care in the compare).
module pattern_seq_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_limit,
`ifdef PATTERN_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               start,
    input  logic               stop,
    input  logic               data_valid,
    input  logic               data_in,
    output logic               busy,
    output logic               pattern_det,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

    state_t state, state_nx;

    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   lim_q;
    logic [MAX_LEN-1:0] shreg;
    logic [LEN_W-1:0]   fill;

    logic               cfg_fire;
    logic               cfg_legal;
    logic               arm;
    logic               beat;
    logic               hit;
    logic [MAX_LEN-1:0] sh_nx;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] cmp_mask;

`ifdef PATTERN_MASK_EN
    logic [MAX_LEN-1:0] mask_q;
`endif

    always_comb begin
        cfg_ready = (state != S_ARMED);
        busy      = (state == S_ARMED);
        done      = (state == S_DONE);
        cfg_fire  = cfg_valid && cfg_ready;
        cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        // a config offer in the same cycle wins over start
        arm       = start && !cfg_fire && (state != S_ARMED) && (len_q != '0);
        beat      = data_valid && (state == S_ARMED);
        sh_nx     = {shreg[MAX_LEN-2:0], data_in};
        fill_inc  = (fill < len_q) ? fill + 1'b1 : fill;
        cnt_inc   = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
        len_mask  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
`ifdef PATTERN_MASK_EN
        cmp_mask  = len_mask & ~mask_q;
`else
        cmp_mask  = len_mask;
`endif
        hit       = beat && (fill_inc >= len_q) && (((sh_nx ^ pat_q) & cmp_mask) == '0);

        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (arm) state_nx = S_ARMED;
            S_ARMED: begin
                if (stop)
                    state_nx = S_IDLE;
                else if (hit && (lim_q != '0) && (cnt_inc == lim_q))
                    state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            lim_q       <= '0;
            shreg       <= '0;
            fill        <= '0;
            match_cnt   <= '0;
            pattern_det <= 1'b0;
            cfg_err     <= 1'b0;
`ifdef PATTERN_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            pattern_det <= hit;
            if (cfg_fire) begin
                if (cfg_legal) begin
                    pat_q   <= cfg_pattern;
                    len_q   <= cfg_len;
                    ovl_q   <= cfg_overlap;
                    lim_q   <= cfg_limit;
                    cfg_err <= 1'b0;
`ifdef PATTERN_MASK_EN
                    mask_q  <= cfg_mask;
`endif
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            if (arm) begin
                shreg     <= '0;
                fill      <= '0;
                match_cnt <= '0;
            end else if (beat) begin
                shreg <= sh_nx;
                // without overlap the next match needs len fresh bits
                fill  <= (hit && !ovl_q) ? '0 : fill_inc;
                if (hit) match_cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb/tb_pattern_seq_ctrl.sv - scoreboard testbench for pattern_seq_ctrl
module tb_pattern_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_limit = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       data_valid = 1'b0;
    logic       data_in = 1'b0;
    logic       busy;
    logic       pattern_det;
    logic [7:0] match_cnt;
    logic       done;
    logic       cfg_err;
`ifdef PATTERN_MASK_EN
    logic [7:0] cfg_mask = '0;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    pattern_seq_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
`ifdef PATTERN_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .start(start), .stop(stop), .data_valid(data_valid), .data_in(data_in),
        .busy(busy), .pattern_det(pattern_det), .match_cnt(match_cnt),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic [7:0] lim);
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_limit = lim;
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cycle(); stop = 1'b0;
    endtask

    // drives one valid beat and records whether a pulse must follow it
    task automatic drive_beat(input logic d, input logic e);
        exp_q.push_back(e);
        data_valid = 1'b1; data_in = d;
        cycle();
        data_valid = 1'b0; data_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; cycle(); cycle(); rst = 1'b1;
        n_assert++;
        if ({cfg_ready, busy, pattern_det, match_cnt, done, cfg_err} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b det=%b cnt=%0d done=%b err=%b, want 1 0 0 0 0 0",
                     cfg_ready, busy, pattern_det, match_cnt, done, cfg_err);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001001;
        logic x;
        do_cfg(8'b1011, 4'd4, 1'b1, 8'd0);
        do_start();
        for (int i = 6; i >= 0; i--) begin
            drive_beat(s[i], e[i]);
            x = exp_q.pop_front();
            n_assert++;
            if (pattern_det !== x) begin
                n_fail++; $display("FAIL overlap_det beat %0d: got %b want %b", 7 - i, pattern_det, x);
            end
        end
        n_assert++;
        if (match_cnt !== 8'd2 || busy !== 1'b1) begin
            n_fail++; $display("FAIL overlap_cnt: got cnt=%0d busy=%b want cnt=2 busy=1", match_cnt, busy);
        end
    endtask

    task automatic test_no_overlap();
        logic [6:0] s = 7'b1011011;
        logic [6:0] e = 7'b0001000;
        logic x;
        do_stop();
        do_cfg(8'b1011, 4'd4, 1'b0, 8'd0);
        do_start();
        for (int i = 6; i >= 0; i--) begin
            drive_beat(s[i], e[i]);
            x = exp_q.pop_front();
            n_assert++;
            if (pattern_det !== x) begin
                n_fail++; $display("FAIL nooverlap_det beat %0d: got %b want %b", 7 - i, pattern_det, x);
            end
        end
        n_assert++;
        if (match_cnt !== 8'd1) begin
            n_fail++; $display("FAIL nooverlap_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_limit();
        logic [9:0] s = 10'b1011011011;
        logic [9:0] e = 10'b0001001000;
        logic x;
        do_stop();
        do_cfg(8'b1011, 4'd4, 1'b1, 8'd2);
        do_start();
        for (int i = 9; i >= 0; i--) begin
            drive_beat(s[i], e[i]);
            x = exp_q.pop_front();
            n_assert++;
            if (pattern_det !== x) begin
                n_fail++; $display("FAIL limit_det beat %0d: got %b want %b", 10 - i, pattern_det, x);
            end
            if (i == 3) begin
                n_assert++;
                if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
                    n_fail++; $display("FAIL limit_done: got done=%b busy=%b rdy=%b want 1 0 1", done, busy, cfg_ready);
                end
            end
        end
        n_assert++;
        if (match_cnt !== 8'd2 || done !== 1'b1) begin
            n_fail++; $display("FAIL limit_hold: got cnt=%0d done=%b want cnt=2 done=1", match_cnt, done);
        end
        do_start();
        n_assert++;
        if (match_cnt !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL limit_rearm: got cnt=%0d busy=%b done=%b want 0 1 0", match_cnt, busy, done);
        end
    endtask

    task automatic test_cfg_err();
        rst = 1'b0; cycle(); rst = 1'b1;
        do_cfg(8'b1011, 4'd0, 1'b1, 8'd0);
        n_assert++;
        if (cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL cfg_err_len0: got %b want 1", cfg_err);
        end
        do_start();
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL cfg_err_start: got busy=%b want 0", busy);
        end
        do_cfg(8'b1011, 4'd9, 1'b1, 8'd0);
        n_assert++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cfg_err_len9: got err=%b busy=%b want 1 0", cfg_err, busy);
        end
        do_cfg(8'b1011, 4'd4, 1'b1, 8'd0);
        n_assert++;
        if (cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err);
        end
        cfg_valid = 1'b1; cfg_len = 4'd0; start = 1'b1;
        cycle();
        cfg_valid = 1'b0; start = 1'b0; cfg_len = 4'd4;
        n_assert++;
        if (busy !== 1'b0 || cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL cfg_and_start: got busy=%b err=%b want 0 1", busy, cfg_err);
        end
    endtask

    task automatic test_stop_history();
        logic [3:0] s = 4'b1011;
        logic x;
        do_start();
        for (int i = 3; i >= 1; i--) begin
            drive_beat(s[i], 1'b0);
            x = exp_q.pop_front();
            n_assert++;
            if (pattern_det !== x) begin
                n_fail++; $display("FAIL hist_pre beat %0d: got %b want %b", 4 - i, pattern_det, x);
            end
        end
        do_stop();
        n_assert++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL stop_idle: got busy=%b rdy=%b want 0 1", busy, cfg_ready);
        end
        do_start();
        drive_beat(1'b1, 1'b0);
        x = exp_q.pop_front();
        n_assert++;
        if (pattern_det !== x) begin
            n_fail++; $display("FAIL hist_cleared: got %b want %b", pattern_det, x);
        end
        for (int i = 3; i >= 0; i--) begin
            cycle(); cycle();
            drive_beat(s[i], i == 0);
            x = exp_q.pop_front();
            n_assert++;
            if (pattern_det !== x) begin
                n_fail++; $display("FAIL gap_det beat %0d: got %b want %b", 4 - i, pattern_det, x);
            end
        end
        cycle();
        n_assert++;
        if (pattern_det !== 1'b0 || match_cnt !== 8'd1) begin
            n_fail++; $display("FAIL gap_pulse_width: got det=%b cnt=%0d want 0 1", pattern_det, match_cnt);
        end
    endtask

    task automatic test_stop_match();
        logic [2:0] s = 3'b101;
        logic x;
        do_stop();
        do_start();
        for (int i = 2; i >= 0; i--) begin
            drive_beat(s[i], 1'b0);
            void'(exp_q.pop_front());
        end
        stop = 1'b1;
        drive_beat(1'b1, 1'b1);
        stop = 1'b0;
        x = exp_q.pop_front();
        n_assert++;
        if (pattern_det !== x || match_cnt !== 8'd1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_with_match: got det=%b cnt=%0d busy=%b want %b 1 0", pattern_det, match_cnt, busy, x);
        end
    endtask

    task automatic test_len_bounds();
        logic [3:0] s1 = 4'b1101;
        logic [7:0] s8 = 8'hA5;
        logic x;
        do_cfg(8'b1, 4'd1, 1'b0, 8'd0);
        do_start();
        for (int i = 3; i >= 0; i--) begin
            drive_beat(s1[i], s1[i]);
            x = exp_q.pop_front();
            n_assert++;
            if (pattern_det !== x) begin
                n_fail++; $display("FAIL len1_det beat %0d: got %b want %b", 4 - i, pattern_det, x);
            end
        end
        do_stop();
        do_cfg(8'hA5, 4'd8, 1'b0, 8'd0);
        do_start();
        for (int i = 7; i >= 0; i--) begin
            drive_beat(s8[i], i == 0);
            x = exp_q.pop_front();
            n_assert++;
            if (pattern_det !== x) begin
                n_fail++; $display("FAIL len8_det beat %0d: got %b want %b", 8 - i, pattern_det, x);
            end
        end
    endtask

`ifdef PATTERN_MASK_EN
    task automatic test_mask();
        logic x;
        do_stop();
        cfg_mask = 8'b0100;
        do_cfg(8'b1011, 4'd4, 1'b1, 8'd0);
        cfg_mask = '0;
        do_start();
        for (int i = 0; i < 4; i++) begin
            drive_beat(1'b1, i == 3);
            x = exp_q.pop_front();
            n_assert++;
            if (pattern_det !== x) begin
                n_fail++; $display("FAIL mask_det beat %0d: got %b want %b", i + 1, pattern_det, x);
            end
        end
    endtask
`endif

    task automatic test_mid_reset();
        logic [7:0] s8 = 8'hA5;
        do_stop();
        do_cfg(8'hA5, 4'd0, 1'b0, 8'd0);
        do_start();
        for (int i = 7; i >= 0; i--) begin
            drive_beat(s8[i], i == 0);
            void'(exp_q.pop_front());
        end
        n_assert++;
        if (pattern_det !== 1'b1 || cfg_err !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got det=%b err=%b busy=%b want 1 1 1", pattern_det, cfg_err, busy);
        end
        rst = 1'b0; data_valid = 1'b1; data_in = 1'b1;
        cycle();
        rst = 1'b1; data_valid = 1'b0; data_in = 1'b0;
        n_assert++;
        if ({cfg_ready, busy, pattern_det, match_cnt, done, cfg_err} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b busy=%b det=%b cnt=%0d done=%b err=%b, want 1 0 0 0 0 0",
                     cfg_ready, busy, pattern_det, match_cnt, done, cfg_err);
        end
        do_start();
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_clears_cfg: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_limit();
        test_cfg_err();
        test_stop_history();
        test_stop_match();
        test_len_bounds();
`ifdef PATTERN_MASK_EN
        test_mask();
`endif
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
